// File: rtl/peak_capture_sampler.sv
// peak_capture_sampler
//   Threshold-triggered ADC sampler with hysteresis and a pre/post-trigger
//   window. Each captured peak is streamed to a downstream FIFO, tagged with
//   its peak index and an end-of-peak flag. Samples refused by a full FIFO
//   are dropped and flagged in a sticky overflow bit.
//
// Ports
//   clk       : clock, all logic on rising edge
//   rst_n     : synchronous active-low reset
//   adc_dat   : live unsigned ADC sample, one per cycle
//   start     : level enable (1 = run, 0 = abort / idle)
//   thr_high  : trigger threshold (strict greater-than)
//   thr_low   : release threshold (strict less-than)
//   nsamples  : per-peak sample cap, 0 = no cap
//   npeaks    : number of peaks to capture per run
//   fifo_full : downstream FIFO full
//   dout      : sample written to the FIFO
//   peak_id   : index of the peak owning dout
//   last      : dout is the final sample of its peak
//   we        : FIFO write strobe
//   cnt       : saturating count of samples written this run
//   overflow  : sticky, a sample was dropped because of fifo_full
//   busy      : run in progress (FILL, ARM, CAPTURE, REARM)
//   finished  : all requested peaks captured
module peak_capture_sampler #(
  parameter int DATA_W    = 10,
  parameter int PRE_DEPTH = 4,
  parameter int CNT_W     = 16,
  parameter int PEAK_W    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_dat,
  input  logic              start,
  input  logic [DATA_W-1:0] thr_high,
  input  logic [DATA_W-1:0] thr_low,
  input  logic [CNT_W-1:0]  nsamples,
  input  logic [PEAK_W-1:0] npeaks,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] dout,
  output logic [PEAK_W-1:0] peak_id,
  output logic              last,
  output logic              we,
  output logic [CNT_W-1:0]  cnt,
  output logic              overflow,
  output logic              busy,
  output logic              finished
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_REARM   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int TW = $clog2(PRE_DEPTH + 1);
  localparam logic [TW-1:0]     FILL_LAST = TW'(PRE_DEPTH - 1);
  localparam logic [TW-1:0]     TAIL_INIT = TW'(PRE_DEPTH);
  localparam logic [TW-1:0]     TW_ONE    = TW'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PEAK_W-1:0] PEAK_ONE  = PEAK_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [2:0]        state, state_nxt;
  logic [TW-1:0]     fill_cnt;
  logic [TW-1:0]     tail_left;
  logic              tail;
  logic [CNT_W-1:0]  pcnt;
  logic [PEAK_W-1:0] peak_cnt;

  logic [DATA_W-1:0] hist_p0 [PRE_DEPTH];
  logic [DATA_W-1:0] tap_p0;

  logic              dec_p0, fin_p0, cap_hit_p0, by_cap_p0;

  logic [DATA_W-1:0] dout_p1;
  logic [PEAK_W-1:0] peak_id_p1;
  logic              last_p1;
  logic              vld_p1;

  assign tap_p0 = hist_p0[PRE_DEPTH-1];

  // Stage 0: write decision and next state from the live sample
  always_comb begin
    dec_p0     = 1'b0;
    fin_p0     = 1'b0;
    by_cap_p0  = 1'b0;
    cap_hit_p0 = (nsamples != '0) && ((pcnt + CNT_ONE) == nsamples);
    state_nxt  = state;

    case (state)
      S_ARM:     dec_p0 = start && (adc_dat > thr_high);
      S_CAPTURE: begin
        dec_p0 = start;
        fin_p0 = tail && (tail_left == TW_ONE);
      end
      default: ;
    endcase

    if (dec_p0 && cap_hit_p0) begin
      fin_p0    = 1'b1;
      by_cap_p0 = 1'b1;
    end

    case (state)
      S_IDLE:  if (start) state_nxt = (npeaks == '0) ? S_DONE : S_FILL;
      S_FILL: begin
        if (!start)                     state_nxt = S_IDLE;
        else if (fill_cnt == FILL_LAST) state_nxt = S_ARM;
      end
      S_ARM, S_CAPTURE: begin
        if (!start) state_nxt = S_IDLE;
        else if (dec_p0 && fin_p0) begin
          // A capped peak may still be above threshold, so it must see a
          // release before another trigger is allowed.
          if ((peak_cnt + PEAK_ONE) == npeaks) state_nxt = S_DONE;
          else if (by_cap_p0)                  state_nxt = S_REARM;
          else                                 state_nxt = S_ARM;
        end else if (dec_p0) state_nxt = S_CAPTURE;
      end
      S_REARM: begin
        if (!start)                 state_nxt = S_IDLE;
        else if (adc_dat < thr_low) state_nxt = S_ARM;
      end
      S_DONE:  if (!start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage 1: registered FIFO write and run bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      fill_cnt   <= '0;
      tail_left  <= '0;
      tail       <= 1'b0;
      pcnt       <= '0;
      peak_cnt   <= '0;
      for (int i = 0; i < PRE_DEPTH; i++) hist_p0[i] <= '0;
      dout_p1    <= '0;
      peak_id_p1 <= '0;
      last_p1    <= 1'b0;
      vld_p1     <= 1'b0;
      cnt        <= '0;
      overflow   <= 1'b0;
      finished   <= 1'b0;
    end else begin
      hist_p0[0] <= adc_dat;
      for (int i = 1; i < PRE_DEPTH; i++) hist_p0[i] <= hist_p0[i-1];

      state   <= state_nxt;
      vld_p1  <= dec_p0 && !fifo_full;
      last_p1 <= dec_p0 && fin_p0 && !fifo_full;
      if (dec_p0) begin
        dout_p1    <= tap_p0;
        peak_id_p1 <= peak_cnt;
        // Dropped samples still advance the per-peak count and tail timing.
        pcnt       <= fin_p0 ? '0 : pcnt + CNT_ONE;
        if (fifo_full) overflow <= 1'b1;
        else           cnt      <= sat_inc(cnt);
        if (fin_p0) begin
          peak_cnt <= peak_cnt + PEAK_ONE;
          tail     <= 1'b0;
        end else if (state == S_CAPTURE && !tail && adc_dat < thr_low) begin
          tail      <= 1'b1;
          tail_left <= TAIL_INIT;
        end else if (tail) begin
          tail_left <= tail_left - TW_ONE;
        end
      end

      if (state == S_FILL && start) fill_cnt <= fill_cnt + TW_ONE;

      if (state == S_IDLE && start) begin
        cnt      <= '0;
        overflow <= 1'b0;
        finished <= 1'b0;
        peak_cnt <= '0;
        fill_cnt <= '0;
        pcnt     <= '0;
        tail     <= 1'b0;
      end
      if (state_nxt == S_DONE) finished <= 1'b1;
    end
  end

  assign dout    = dout_p1;
  assign peak_id = peak_id_p1;
  assign last    = last_p1;
  assign we      = vld_p1;
  assign busy    = (state == S_FILL) || (state == S_ARM) ||
                   (state == S_CAPTURE) || (state == S_REARM);

endmodule
